jk_bank_sequencer: RTL and testbench

JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

---
 rtl/jk_bank_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command sequencer driving J/K inputs of a bank of JK flip-flop cells
//
// Accepts one command at a time and sequences the J/K drive of WIDTH external
// JK cells through APPLY/SETTLE phases. j/k are nonzero only in APPLY and hold
// (all-zero) otherwise. COUNT commands repeat APPLY/SETTLE cmd_count times,
// recomputing the toggle vector from the settled q each step.
//
// Optional feature macro: JK_SEQ_COUNT_DOWN_EN
//    defined   -> opcode 110 performs COUNT_DOWN
//    undefined -> opcode 110 is illegal (ERR state, err pulse)
//
// Ports:
//    clk        in   clock, all state changes on posedge
//    reset      in   synchronous active-low reset
//    cmd_valid  in   command request
//    cmd_ready  out  command accepted when high with cmd_valid (IDLE only)
//    cmd        in   3-bit opcode
//    cmd_data   in   LOAD value / TOGGLE mask
//    cmd_count  in   step count for COUNT_UP/COUNT_DOWN
//    q          in   current Q outputs of the cell bank
//    j, k       out  registered J/K drive per cell
//    busy       out  high in every state except IDLE
//    done       out  one-cycle pulse on completion
//    err        out  one-cycle pulse on illegal/disabled opcode

module jk_bank_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_CLEAR  = 3'b001;
   localparam logic [2:0] OP_SET    = 3'b010;
   localparam logic [2:0] OP_LOAD   = 3'b011;
   localparam logic [2:0] OP_TOGGLE = 3'b100;
   localparam logic [2:0] OP_UP     = 3'b101;
   localparam logic [2:0] OP_DOWN   = 3'b110;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   j_q, j_d;
   logic [WIDTH-1:0]   k_q, k_d;

   logic               accept;
   logic               go_apply;
   logic [2:0]         apply_op;
   logic [WIDTH-1:0]   apply_data;
   logic [WIDTH-1:0]   t_up;

   function automatic logic op_is_count(input logic [2:0] op);
      return (op == OP_UP) || (op == OP_DOWN);
   endfunction

   function automatic logic op_is_legal(input logic [2:0] op);
      logic legal;
      legal = 1'b1;
      if (op == 3'b111) begin
         legal = 1'b0;
      end
`ifndef JK_SEQ_COUNT_DOWN_EN
      if (op == OP_DOWN) begin
         legal = 1'b0;
      end
`endif
      return legal;
   endfunction

   assign accept = cmd_valid & cmd_ready;

   // j/k are registered on the edge that enters APPLY, so the q seen here is
   // the value settled during the previous SETTLE (or idle) cycle and remains
   // stable through the APPLY cycle itself.
   always_comb begin
      t_up    = '0;
      t_up[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t_up[i] = t_up[i-1] & q[i-1];
      end
   end

`ifdef JK_SEQ_COUNT_DOWN_EN
   logic [WIDTH-1:0] t_down;

   always_comb begin
      t_down    = '0;
      t_down[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t_down[i] = t_down[i-1] & ~q[i-1];
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      j_d        = '0;
      k_d        = '0;
      go_apply   = 1'b0;
      apply_op   = op_q;
      apply_data = data_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d   = cmd;
               data_d = cmd_data;
               // Non-count commands are a single step.
               cnt_d  = op_is_count(cmd) ? cmd_count : CNT_ONE;
               if (!op_is_legal(cmd)) begin
                  state_d = S_ERR;
               end else if ((cmd == OP_NOP) ||
                            (op_is_count(cmd) && (cmd_count == '0))) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_APPLY;
                  go_apply   = 1'b1;
                  apply_op   = cmd;
                  apply_data = cmd_data;
               end
            end
         end
         S_APPLY: begin
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q > CNT_ONE) begin
               cnt_d    = cnt_q - CNT_ONE;
               state_d  = S_APPLY;
               go_apply = 1'b1;
            end else begin
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (go_apply) begin
         case (apply_op)
            OP_CLEAR: begin
               k_d = '1;
            end
            OP_SET: begin
               j_d = '1;
            end
            OP_LOAD: begin
               j_d = apply_data;
               k_d = ~apply_data;
            end
            OP_TOGGLE: begin
               j_d = apply_data;
               k_d = apply_data;
            end
            OP_UP: begin
               j_d = t_up;
               k_d = t_up;
            end
`ifdef JK_SEQ_COUNT_DOWN_EN
            OP_DOWN: begin
               j_d = t_down;
               k_d = t_down;
            end
`endif
            default: begin
               j_d = '0;
               k_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_NOP;
         data_q  <= '0;
         cnt_q   <= '0;
         j_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         j_q     <= j_d;
         k_q     <= k_d;
      end
   end

   // Gated by reset so no command can be offered while reset is held.
   assign cmd_ready = reset & (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign j         = j_q;
   assign k         = k_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - randomized self-checking bench for jk_bank_sequencer
module tb_jk_bank_sequencer;

   localparam int W  = 4;
   localparam int CW = 4;

`ifdef JK_SEQ_COUNT_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd;
   logic [W-1:0]  cmd_data;
   logic [CW-1:0] cmd_count;
   logic [W-1:0]  q_cells;
   logic [W-1:0]  j;
   logic [W-1:0]  k;
   logic          busy;
   logic          done;
   logic          err;

   logic          preset_en;
   logic [W-1:0]  preset_val;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   jk_bank_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .q         (q_cells),
      .j         (j),
      .k         (k),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // Behavioural JK cell bank: 00 hold, 01 reset, 10 set, 11 toggle.
   always @(posedge clk) begin
      if (preset_en) q_cells <= preset_val;
      else           q_cells <= (q_cells & ~k) | (~q_cells & j);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit legal_op(input logic [2:0] op);
      if (op == 3'd7) return 1'b0;
      if (op == 3'd6) return DOWN_EN;
      return 1'b1;
   endfunction

   task automatic set_q(input logic [W-1:0] v);
      @(negedge clk);
      preset_val = v;
      preset_en  = 1'b1;
      @(negedge clk);
      preset_en  = 1'b0;
   endtask

   // Issues one command, then compares every busy cycle against an expected
   // per-cycle trace derived from the arithmetic effect of the command.
   task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data,
                          input logic [CW-1:0] cnt, input bit poke, input string name);
      logic [W-1:0] ej[$];
      logic [W-1:0] ek[$];
      bit           ed[$];
      bit           ee[$];
      logic [W-1:0] qq;
      logic [W-1:0] t;
      logic [W-1:0] dj;
      logic [W-1:0] dk;
      int           steps;
      int           idx;
      qq = q_cells;
      if (!legal_op(op)) begin
         ej.push_back('0); ek.push_back('0); ed.push_back(1'b0); ee.push_back(1'b1);
      end else if (op == 3'd0 || ((op == 3'd5 || op == 3'd6) && cnt == '0)) begin
         ej.push_back('0); ek.push_back('0); ed.push_back(1'b1); ee.push_back(1'b0);
      end else begin
         steps = (op == 3'd5 || op == 3'd6) ? int'(cnt) : 1;
         for (int s = 0; s < steps; s++) begin
            dj = '0; dk = '0;
            case (op)
               3'd1: begin dk = '1; qq = '0; end
               3'd2: begin dj = '1; qq = '1; end
               3'd3: begin dj = data; dk = ~data; qq = data; end
               3'd4: begin dj = data; dk = data; qq = qq ^ data; end
               3'd5: begin t = qq ^ (qq + 1'b1); dj = t; dk = t; qq = qq + 1'b1; end
               default: begin t = qq ^ (qq - 1'b1); dj = t; dk = t; qq = qq - 1'b1; end
            endcase
            ej.push_back(dj); ek.push_back(dk); ed.push_back(1'b0); ee.push_back(1'b0);
            ej.push_back('0); ek.push_back('0); ed.push_back(1'b0); ee.push_back(1'b0);
         end
         ej.push_back('0); ek.push_back('0); ed.push_back(1'b1); ee.push_back(1'b0);
      end

      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s ready_before: got %b want 1", name, cmd_ready);
      end
      cmd = op; cmd_data = data; cmd_count = cnt; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = 3'($urandom_range(0, 7));
      cmd_data  = W'($urandom_range(0, 15));
      idx = 0;
      while (busy === 1'b1 && idx < 64) begin
         n_cmp++;
         if (idx >= ej.size()) begin
            n_bad++;
            $display("FAIL %s extra_busy_cycle %0d: got j=%b k=%b", name, idx, j, k);
         end else if ({j, k, done, err} !== {ej[idx], ek[idx], ed[idx], ee[idx]}) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got j=%b k=%b done=%b err=%b want j=%b k=%b done=%b err=%b",
                     name, idx, j, k, done, err, ej[idx], ek[idx], ed[idx], ee[idx]);
         end
         if (poke && idx == 1) begin
            cmd_valid = 1'b1;
            cmd       = 3'($urandom_range(1, 5));
            cmd_count = CW'($urandom_range(1, 9));
         end
         if (idx == 2) cmd_valid = 1'b0;
         idx++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      n_cmp++;
      if (idx != ej.size()) begin
         n_bad++;
         $display("FAIL %s busy_cycles: got %0d want %0d", name, idx, ej.size());
      end
      n_cmp++;
      if (q_cells !== qq) begin
         n_bad++;
         $display("FAIL %s final_q: got %b want %b", name, q_cells, qq);
      end
      n_cmp++;
      if ({cmd_ready, busy, done, err, j, k} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}}) begin
         n_bad++;
         $display("FAIL %s idle_after: got ready=%b busy=%b done=%b err=%b j=%b k=%b",
                  name, cmd_ready, busy, done, err, j, k);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; cmd_valid = 1'b1; cmd = 3'd3; cmd_data = 4'b1111; cmd_count = '0;
      preset_val = '0; preset_en = 1'b1;
      repeat (3) @(negedge clk);
      preset_en = 1'b0;
      n_cmp++;
      if ({cmd_ready, busy, done, err, j, k} !== {1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}}) begin
         n_bad++;
         $display("FAIL reset_state: got ready=%b busy=%b done=%b err=%b j=%b k=%b",
                  cmd_ready, busy, done, err, j, k);
      end
      cmd_valid = 1'b0;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_load();
      set_q(4'b0000);
      run_cmd(3'd3, 4'b1010, '0, 1'b0, "load_1010");
   endtask

   task automatic test_count_up();
      set_q(4'b1110);
      run_cmd(3'd5, '0, 4'd3, 1'b1, "count_up_3");
      set_q(4'b1111);
      run_cmd(3'd5, '0, 4'd1, 1'b0, "count_up_wrap");
      run_cmd(3'd5, '0, 4'd0, 1'b0, "count_up_zero");
   endtask

   task automatic test_count_down();
      set_q(4'b0000);
      run_cmd(3'd6, '0, 4'd1, 1'b0, "count_down_wrap");
      set_q(4'b0101);
      run_cmd(3'd6, '0, 4'd4, 1'b1, "count_down_4");
   endtask

   task automatic test_misc_ops();
      set_q(4'b0110);
      run_cmd(3'd1, '0, '0, 1'b0, "clear");
      run_cmd(3'd2, '0, '0, 1'b1, "set");
      run_cmd(3'd4, 4'b1001, '0, 1'b0, "toggle");
      run_cmd(3'd0, 4'b1111, 4'd5, 1'b0, "nop");
      run_cmd(3'd7, 4'b1111, 4'd5, 1'b0, "illegal_111");
   endtask

   task automatic test_midop_reset();
      logic [W-1:0] qq;
      logic [W-1:0] t;
      logic [W-1:0] want;
      int           idx;
      int           seen_done;
      set_q(4'b0011);
      qq = 4'b0011;
      @(negedge clk);
      cmd = 3'd5; cmd_count = 4'd8; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (idx = 0; idx < 6; idx++) begin
         t = qq ^ (qq + 1'b1);
         want = (idx % 2 == 0) ? t : '0;
         n_cmp++;
         if ({busy, j, k} !== {1'b1, want, want}) begin
            n_bad++;
            $display("FAIL midop cycle %0d: got busy=%b j=%b k=%b want busy=1 j=k=%b",
                     idx, busy, j, k, want);
         end
         if (idx % 2 == 1) qq = qq + 1'b1;
         if (idx == 2) cmd_valid = 1'b1;
         if (idx == 3) cmd_valid = 1'b0;
         if (idx < 5) @(negedge clk);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({cmd_ready, busy, done, err, j, k} !== {1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}}) begin
         n_bad++;
         $display("FAIL midop_reset_state: got ready=%b busy=%b done=%b err=%b j=%b k=%b",
                  cmd_ready, busy, done, err, j, k);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL midop_ready_after_release: got %b want 1", cmd_ready);
      end
      seen_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen_done++;
      end
      n_cmp++;
      if (seen_done != 0) begin
         n_bad++;
         $display("FAIL midop_no_done: got %0d active cycles want 0", seen_done);
      end
      n_cmp++;
      if (q_cells !== qq) begin
         n_bad++;
         $display("FAIL midop_q: got %b want %b", q_cells, qq);
      end
   endtask

   task automatic test_random();
      logic [2:0]    op;
      logic [W-1:0]  data;
      logic [CW-1:0] cnt;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0) set_q(W'($urandom_range(0, 15)));
         op   = 3'($urandom_range(0, 7));
         data = W'($urandom_range(0, 15));
         cnt  = CW'($urandom_range(0, 6));
         run_cmd(op, data, cnt, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", n, op));
      end
   endtask

   task automatic test_back_to_back();
      set_q(4'b1101);
      run_cmd(3'd5, '0, 4'd2, 1'b0, "b2b_up");
      run_cmd(3'd4, 4'b0110, '0, 1'b0, "b2b_toggle");
      run_cmd(3'd3, 4'b0001, '0, 1'b0, "b2b_load");
      run_cmd(3'd6, '0, 4'd2, 1'b0, "b2b_down");
   endtask

   initial begin
      test_reset();
      test_load();
      test_count_up();
      test_count_down();
      test_misc_ops();
      test_midop_reset();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
